demux1a2_router: RTL and testbench

- Registered 1-to-2 demultiplexer; the inverse of the registered 2:1 nibble mux.
- Takes a single W-bit data stream with valid/ready and steers each word to output channel A or B.
- Each channel has a one-entry output register.
- Sits between a shared source (bus / serial deframer) and two independent consumers, e.g. the two digit/register paths that feed the mux.

---
 rtl/demux1a2_router_pkg.sv | 13 +
 rtl/demux1a2_router_out_reg_slot.sv | 54 +++++
 rtl/demux1a2_router.sv | 80 ++++++++
 tb/tb_demux1a2_router.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux1a2_router_pkg.sv
// Shared definitions for the 1-to-2 registered demultiplexer: channel indices
// and the auto-alternation pointer state.
package demux1a2_router_pkg;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_e;

endpackage

// File: rtl/demux1a2_router_out_reg_slot.sv
// One-entry valid/ready output register with a wrapping delivery counter.
// A load and a drain may happen on the same edge, which sustains 1 word/cycle.
module demux1a2_router_out_reg_slot #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             free
);

    logic [W-1:0]     data_q,  data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            count_d = count_q + CNT_W'(1);
        end
        // A new word overrides the clear from a same-cycle delivery.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_count = count_q;
    assign free      = ~valid_q | out_ready;

endmodule

// File: rtl/demux1a2_router.sv
// Registered 1-to-2 demultiplexer: steers each accepted input word into the
// A or B output register, by in_sel or by an alternating pointer.
module demux1a2_router
    import demux1a2_router_pkg::*;
#(
    parameter int W        = 4,
    parameter int AUTO_SEL = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [W-1:0]     in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             frame,
    output logic [W-1:0]     a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [W-1:0]     b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    ptr_e ptr_q, ptr_d;
    logic dest;
    logic accept;
    logic a_free, b_free;

    assign dest     = (AUTO_SEL != 0) ? (ptr_q == PTR_B) : in_sel;
    assign in_ready = (dest == CH_B) ? b_free : a_free;
    assign accept   = in_valid & in_ready;

    // frame beats the toggle; the word accepted alongside it used ptr_q already.
    always_comb begin
        ptr_d = ptr_q;
        if (AUTO_SEL != 0) begin
            if (frame) begin
                ptr_d = PTR_A;
            end else if (accept) begin
                ptr_d = (ptr_q == PTR_A) ? PTR_B : PTR_A;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= PTR_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    demux1a2_router_out_reg_slot #(.W(W), .CNT_W(CNT_W)) u_slot_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (accept & (dest == CH_A)),
        .load_data (in_data),
        .out_ready (a_ready),
        .out_data  (a_data),
        .out_valid (a_valid),
        .out_count (a_count),
        .free      (a_free)
    );

    demux1a2_router_out_reg_slot #(.W(W), .CNT_W(CNT_W)) u_slot_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (accept & (dest == CH_B)),
        .load_data (in_data),
        .out_ready (b_ready),
        .out_data  (b_data),
        .out_valid (b_valid),
        .out_count (b_count),
        .free      (b_free)
    );

endmodule

// File: tb/tb_demux1a2_router.sv
// Bench for demux1a2_router: one instance routing by in_sel, one auto-alternating,
// both driven by the same stimulus and checked against queue-based models.
module tb_demux1a2_router;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       frame = 1'b0;
    logic       a_ready = 1'b0;
    logic       b_ready = 1'b0;

    logic       in_ready [2];
    logic [3:0] a_data [2];
    logic [3:0] b_data [2];
    logic       a_valid [2];
    logic       b_valid [2];
    logic [7:0] a_count [2];
    logic [7:0] b_count [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per DUT, per channel queue of words owed to the consumer.
    logic [3:0] q0a[$], q0b[$], q1a[$], q1b[$];
    logic [7:0] m_cnt [2][2];
    logic       m_ptr [2];

    always #5 clk = ~clk;

    demux1a2_router #(.W(4), .AUTO_SEL(0), .CNT_W(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready[0]), .frame(frame),
        .a_data(a_data[0]), .a_valid(a_valid[0]), .a_ready(a_ready),
        .b_data(b_data[0]), .b_valid(b_valid[0]), .b_ready(b_ready),
        .a_count(a_count[0]), .b_count(b_count[0])
    );

    demux1a2_router #(.W(4), .AUTO_SEL(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready[1]), .frame(frame),
        .a_data(a_data[1]), .a_valid(a_valid[1]), .a_ready(a_ready),
        .b_data(b_data[1]), .b_valid(b_valid[1]), .b_ready(b_ready),
        .a_count(a_count[1]), .b_count(b_count[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor one channel: valid must match model occupancy, data must match head.
    task automatic mon_ch(input string name, input logic v, input logic [3:0] d,
                          input logic [7:0] c, input logic rdy, input int dd, input int ch,
                          inout logic [3:0] q[$]);
        chk({name, "_valid"}, v, q.size() != 0);
        chk({name, "_count"}, c, m_cnt[dd][ch]);
        if (q.size() != 0) begin
            chk({name, "_data"}, d, q[0]);
            if (rdy) begin
                void'(q.pop_front());
                m_cnt[dd][ch] = m_cnt[dd][ch] + 8'd1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            q0a.delete(); q0b.delete(); q1a.delete(); q1b.delete();
            for (int d = 0; d < 2; d++) begin
                m_cnt[d][0] = '0;
                m_cnt[d][1] = '0;
                m_ptr[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic dst, free_a, free_b, exp_rdy, acc;
                free_a  = ((d == 0) ? q0a.size() == 0 : q1a.size() == 0) | a_ready;
                free_b  = ((d == 0) ? q0b.size() == 0 : q1b.size() == 0) | b_ready;
                dst     = (d == 1) ? m_ptr[d] : in_sel;
                exp_rdy = dst ? free_b : free_a;
                chk((d == 0) ? "in_ready_sel" : "in_ready_auto", in_ready[d], exp_rdy);
                if (d == 0) begin
                    mon_ch("a_sel", a_valid[0], a_data[0], a_count[0], a_ready, 0, 0, q0a);
                    mon_ch("b_sel", b_valid[0], b_data[0], b_count[0], b_ready, 0, 1, q0b);
                end else begin
                    mon_ch("a_auto", a_valid[1], a_data[1], a_count[1], a_ready, 1, 0, q1a);
                    mon_ch("b_auto", b_valid[1], b_data[1], b_count[1], b_ready, 1, 1, q1b);
                end
                acc = in_valid & exp_rdy;
                if (acc) begin
                    if (d == 0) begin
                        if (dst) q0b.push_back(in_data); else q0a.push_back(in_data);
                    end else begin
                        if (dst) q1b.push_back(in_data); else q1a.push_back(in_data);
                    end
                end
                if (d == 1) begin
                    if (frame) m_ptr[d] = 1'b0;
                    else if (acc) m_ptr[d] = ~m_ptr[d];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d, input logic s, input logic v, input logic f);
        in_data = d; in_sel = s; in_valid = v; frame = f;
    endtask

    task automatic check_all_clear(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_a_valid"}, a_valid[d], 1'b0);
            chk({tag, "_b_valid"}, b_valid[d], 1'b0);
            chk({tag, "_a_data"}, a_data[d], 4'h0);
            chk({tag, "_b_data"}, b_data[d], 4'h0);
            chk({tag, "_a_count"}, a_count[d], 8'h0);
            chk({tag, "_b_count"}, b_count[d], 8'h0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] cnt_before;
        // Reset and idle
        a_ready = 1'b0; b_ready = 1'b0;
        #3;
        check_all_clear("reset");
        chk("reset_in_ready", in_ready[0], 1'b1);
        chk("reset_in_ready_auto", in_ready[1], 1'b1);
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();

        // Routing by in_sel, both consumers ready
        a_ready = 1'b1; b_ready = 1'b1;
        drive(4'd3, 1'b0, 1'b1, 1'b0); cyc();
        chk("seq_a3", a_data[0], 4'd3);
        drive(4'd9, 1'b1, 1'b1, 1'b0); cyc();
        chk("seq_b9", b_data[0], 4'd9);
        drive(4'd5, 1'b0, 1'b1, 1'b0); cyc();
        chk("seq_a5", a_data[0], 4'd5);
        drive(4'd0, 1'b0, 1'b0, 1'b0); cyc();
        chk("seq_a_count", a_count[0], 8'd2);
        chk("seq_b_count", b_count[0], 8'd1);

        // Backpressure on A while B keeps flowing
        a_ready = 1'b0;
        drive(4'd7, 1'b0, 1'b1, 1'b0); cyc();
        chk("bp_a7", a_data[0], 4'd7);
        cnt_before = a_count[0];
        drive(4'd2, 1'b0, 1'b1, 1'b0); #1;
        chk("bp_in_ready_low", in_ready[0], 1'b0);
        cyc();
        chk("bp_a7_held", a_data[0], 4'd7);
        chk("bp_a_valid_held", a_valid[0], 1'b1);
        drive(4'd4, 1'b1, 1'b1, 1'b0); #1;
        chk("bp_in_ready_b", in_ready[0], 1'b1);
        cyc();
        chk("bp_b4", b_data[0], 4'd4);
        chk("bp_a7_still", a_data[0], 4'd7);
        drive(4'd2, 1'b0, 1'b1, 1'b0); a_ready = 1'b1; #1;
        chk("bp_in_ready_drain", in_ready[0], 1'b1);
        cyc();
        chk("bp_a2_loaded", a_data[0], 4'd2);
        chk("bp_a_count", a_count[0], cnt_before + 8'd1);
        drive(4'd0, 1'b0, 1'b0, 1'b0); cyc();

        // Auto alternation and frame
        do_reset();
        a_ready = 1'b1; b_ready = 1'b1;
        drive(4'd1, 1'b0, 1'b1, 1'b0); cyc(); chk("auto_a1", a_data[1], 4'd1);
        drive(4'd2, 1'b0, 1'b1, 1'b0); cyc(); chk("auto_b2", b_data[1], 4'd2);
        drive(4'd3, 1'b0, 1'b1, 1'b0); cyc(); chk("auto_a3", a_data[1], 4'd3);
        drive(4'd4, 1'b0, 1'b1, 1'b0); cyc(); chk("auto_b4", b_data[1], 4'd4);
        drive(4'd5, 1'b0, 1'b1, 1'b0); cyc(); chk("auto_a5", a_data[1], 4'd5);
        drive(4'd0, 1'b0, 1'b0, 1'b1); cyc();
        drive(4'd6, 1'b0, 1'b1, 1'b0); cyc(); chk("frame_a6", a_data[1], 4'd6);
        drive(4'd7, 1'b0, 1'b1, 1'b1); cyc(); chk("frame_acc_b7", b_data[1], 4'd7);
        drive(4'd8, 1'b0, 1'b1, 1'b0); cyc(); chk("frame_after_a8", a_data[1], 4'd8);
        drive(4'd0, 1'b0, 1'b0, 1'b0); cyc();

        // Random traffic, with one asynchronous reset mid-burst
        for (int i = 0; i < 2000; i++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
            a_ready = 1'($urandom_range(0, 2) != 0);
            b_ready = 1'($urandom_range(0, 2) != 0);
            if (i == 1000) begin
                #1 reset_n = 1'b0;
                #1;
                check_all_clear("async_reset");
                chk("async_in_ready", in_ready[0], 1'b1);
                cyc();
                reset_n = 1'b1;
            end else begin
                cyc();
            end
        end

        // Counter wrap on B
        do_reset();
        a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(4'(i), 1'b1, 1'b1, 1'b0);
            cyc();
        end
        drive(4'd0, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        chk("wrap_b_count", b_count[0], 8'd0);
        chk("wrap_a_count", a_count[0], 8'd0);
        chk("wrap_b_valid", b_valid[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
